enemy_wave_ctrl: RTL

- Parametrised attack-phase sequencer for the enemy turn; successor to the fixed three-arrow enemy controller.
- Reads a per-turn pattern table through a synchronous ROM port and times each launch in tick units.
- Allocates launches onto a pool of NUM_SLOTS arrow instances, then drains them.
- Aggregates hits into damage pulses and a hit count, and reports busy/finished to the game state machine.

---
 rtl/enemy_wave_ctrl_if.sv | 25 ++
 rtl/enemy_wave_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_wave_ctrl_if.sv
// Pattern ROM port and arrow-pool launch bus between the enemy wave sequencer
// and the arrow instances.
interface enemy_wave_ctrl_if #(
   parameter int NUM_SLOTS = 24,
   parameter int IDX_W     = 4
);
   logic [4+IDX_W-1:0]   pat_addr_out;
   logic [9:0]           pat_data_in;
   logic [NUM_SLOTS-1:0] slot_active_in;
   logic [NUM_SLOTS-1:0] slot_hit_in;
   logic [NUM_SLOTS-1:0] slot_launch_out;
   logic [1:0]           launch_dir_out;
   logic                 launch_inv_out;
   logic [3:0]           launch_speed_out;

   modport master (
      output pat_addr_out, slot_launch_out, launch_dir_out, launch_inv_out, launch_speed_out,
      input  pat_data_in, slot_active_in, slot_hit_in
   );

   modport slave (
      input  pat_addr_out, slot_launch_out, launch_dir_out, launch_inv_out, launch_speed_out,
      output pat_data_in, slot_active_in, slot_hit_in
   );
endinterface

// File: rtl/enemy_wave_ctrl.sv
// Enemy-turn attack sequencer: walks a per-turn pattern table, times launches in
// tick units, allocates them onto the arrow pool, drains, and tallies hits.
module enemy_wave_ctrl #(
   parameter int          NUM_SLOTS    = 24,
   parameter int          IDX_W        = 4,
   parameter int unsigned TICK_CYCLES  = 6500000,
   parameter logic [3:0]  ATTACK_STATE = 4'b1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         state_in,
   input  logic [3:0]         turn_in,
   enemy_wave_ctrl_if.master  bus,
   output logic               busy_out,
   output logic               finished_out,
   output logic               damage_out,
   output logic [7:0]         hit_count_out
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_WAIT   = 3'd3,
      S_ALLOC  = 3'd4,
      S_DRAIN  = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

   state_t               state_r;
   state_t               state_nx_s;
   logic [3:0]           old_state_r;
   logic [3:0]           bank_r;
   logic [IDX_W-1:0]     index_r;
   logic [1:0]           dir_r;
   logic                 inv_r;
   logic [3:0]           speed_r;
   logic [31:0]          tick_cnt_r;
   logic [31:0]          tick_tgt_r;
   logic [NUM_SLOTS-1:0] launch_prev_r;
   logic [NUM_SLOTS-1:0] launch_s;
   logic [NUM_SLOTS-1:0] free_s;
   logic [NUM_SLOTS-1:0] pick_s;
   logic                 found_s;
   logic                 launch_any_s;
   logic                 start_s;
   logic                 abort_s;
   logic [2:0]           gap_s;
   logic                 busy_r;
   logic                 finished_r;
   logic                 damage_r;
   logic [7:0]           hit_cnt_r;

   function automatic logic [5:0] popcount(input logic [NUM_SLOTS-1:0] v);
      logic [5:0] c;
      c = 6'd0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         c = c + {5'd0, v[i]};
      end
      return c;
   endfunction

   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [5:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {3'b000, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   assign start_s = (state_in == ATTACK_STATE) && (old_state_r != state_in);
   assign abort_s = (state_in != ATTACK_STATE);
   assign gap_s   = bus.pat_data_in[9:7];
   // A slot launched last cycle may not show as active yet, so it is excluded.
   assign free_s  = ~bus.slot_active_in & ~launch_prev_r;

   // Lowest-index free slot as a one-hot vector.
   always_comb begin
      pick_s  = {NUM_SLOTS{1'b0}};
      found_s = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (free_s[i] && !found_s) begin
            pick_s[i] = 1'b1;
            found_s   = 1'b1;
         end else begin
            pick_s[i] = 1'b0;
         end
      end
   end

   // Next-state and launch pulse; abort and reset both suppress the pulse.
   always_comb begin
      state_nx_s = state_r;
      launch_s   = {NUM_SLOTS{1'b0}};
      case (state_r)
         S_IDLE: begin
            if (start_s) begin
               state_nx_s = S_FETCH;
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         S_FETCH:  state_nx_s = S_DECODE;
         S_DECODE: begin
            if (gap_s == 3'd0) begin
               state_nx_s = S_DRAIN;
            end else begin
               state_nx_s = S_WAIT;
            end
         end
         S_WAIT: begin
            if (tick_cnt_r == tick_tgt_r) begin
               state_nx_s = S_ALLOC;
            end else begin
               state_nx_s = S_WAIT;
            end
         end
         S_ALLOC: begin
            if (found_s) begin
               launch_s = pick_s;
               if (index_r == LAST_IDX) begin
                  state_nx_s = S_DRAIN;
               end else begin
                  state_nx_s = S_FETCH;
               end
            end else begin
               state_nx_s = S_ALLOC;
            end
         end
         S_DRAIN: begin
            if ((bus.slot_active_in == {NUM_SLOTS{1'b0}}) && (launch_prev_r == {NUM_SLOTS{1'b0}})) begin
               state_nx_s = S_DONE;
            end else begin
               state_nx_s = S_DRAIN;
            end
         end
         S_DONE:  state_nx_s = S_IDLE;
         default: state_nx_s = S_IDLE;
      endcase
      if ((state_r != S_IDLE) && abort_s) begin
         state_nx_s = S_IDLE;
         launch_s   = {NUM_SLOTS{1'b0}};
      end else begin
         state_nx_s = state_nx_s;
      end
      if (!rst) begin
         launch_s = {NUM_SLOTS{1'b0}};
      end else begin
         launch_s = launch_s;
      end
   end

   assign launch_any_s         = |launch_s;
   assign bus.slot_launch_out  = launch_s;
   assign bus.launch_dir_out   = launch_any_s ? dir_r : 2'b00;
   assign bus.launch_inv_out   = launch_any_s ? inv_r : 1'b0;
   assign bus.launch_speed_out = launch_any_s ? speed_r : 4'd0;
   assign bus.pat_addr_out     = {bank_r, index_r};

   // State register and phase status flags.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r       <= S_IDLE;
         old_state_r   <= 4'hF;
         launch_prev_r <= {NUM_SLOTS{1'b0}};
         busy_r        <= 1'b0;
         finished_r    <= 1'b0;
      end else begin
         state_r       <= state_nx_s;
         old_state_r   <= state_in;
         launch_prev_r <= launch_s;
         busy_r        <= state_nx_s inside {S_FETCH, S_DECODE, S_WAIT, S_ALLOC, S_DRAIN};
         finished_r    <= (state_nx_s == S_DONE);
      end
   end

   // Pattern walk: bank/index, latched entry fields, and gap timer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         bank_r     <= 4'd0;
         index_r    <= {IDX_W{1'b0}};
         dir_r      <= 2'b00;
         inv_r      <= 1'b0;
         speed_r    <= 4'd0;
         tick_cnt_r <= 32'd0;
         tick_tgt_r <= 32'd0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start_s) begin
                  bank_r  <= turn_in;
                  index_r <= {IDX_W{1'b0}};
               end
            end
            S_DECODE: begin
               if (gap_s != 3'd0) begin
                  dir_r      <= bus.pat_data_in[6:5];
                  inv_r      <= bus.pat_data_in[4];
                  speed_r    <= bus.pat_data_in[3:0];
                  tick_cnt_r <= 32'd0;
                  tick_tgt_r <= (32'(gap_s) * TICK_CYCLES) - 32'd1;
               end
            end
            S_WAIT:  tick_cnt_r <= tick_cnt_r + 32'd1;
            S_ALLOC: begin
               if (launch_any_s && (index_r != LAST_IDX)) begin
                  index_r <= index_r + {{(IDX_W-1){1'b0}}, 1'b1};
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Hit aggregation, only while the phase is busy.
   always_ff @(posedge clk) begin
      if (!rst) begin
         damage_r  <= 1'b0;
         hit_cnt_r <= 8'd0;
      end else begin
         damage_r <= busy_r & (|bus.slot_hit_in);
         if ((state_r == S_IDLE) && start_s) begin
            hit_cnt_r <= 8'd0;
         end else if (busy_r) begin
            hit_cnt_r <= sat_add(hit_cnt_r, popcount(bus.slot_hit_in));
         end
      end
   end

   assign busy_out      = busy_r;
   assign finished_out  = finished_r;
   assign damage_out    = damage_r;
   assign hit_count_out = hit_cnt_r;

endmodule
